// File: rtl/alu_pkg.sv
// Shared opcode encodings, scheduler states and the illegal-operation predicate
// for the ALU request scheduler.
package alu_pkg;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] LAND = 3'b010;
    localparam logic [2:0] LOR  = 3'b011;
    localparam logic [2:0] ADC  = 3'b100;
    localparam logic [2:0] LXOR = 3'b101;
    localparam logic [2:0] SBB  = 3'b110;
    localparam logic [2:0] RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } alu_state_t;

    // Carry-in forms are undefined in mode 1, and the reserved code never executes.
    function automatic logic is_illegal_op(input logic [2:0] opsel, input logic mode);
        return (opsel == RSVD) || (mode && ((opsel == ADC) || (opsel == SBB)));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request after last_grant wins,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = (int'(last_grant) + i) % int'(NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: grant, register operands,
// capture the result one cycle later and hold it until the response is taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH = 128,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DWIDTH-1:0] req_op1,
    input  logic [NREQ*DWIDTH-1:0] req_op2,
    input  logic [NREQ*3-1:0]    req_opsel,
    input  logic [NREQ-1:0]      req_mode,
    output logic [DWIDTH-1:0]    alu_op1,
    output logic [DWIDTH-1:0]    alu_op2,
    output logic [2:0]           alu_opsel,
    output logic                 alu_mode,
    input  logic [DWIDTH-1:0]    alu_result,
    input  logic                 alu_c,
    input  logic                 alu_z,
    input  logic                 alu_o,
    input  logic                 alu_s,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DWIDTH-1:0]    rsp_result,
    output logic                 rsp_c,
    output logic                 rsp_z,
    output logic                 rsp_o,
    output logic                 rsp_s,
    output logic                 rsp_err
);

    alu_state_t state_q, state_d;

    logic [IDW-1:0]    last_grant_q;
    logic [IDW-1:0]    id_q;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic              accept;
    logic              illegal;

    logic [DWIDTH-1:0] alu_op1_q, alu_op2_q;
    logic [2:0]        alu_opsel_q;
    logic              alu_mode_q;

    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [DWIDTH-1:0] rsp_result_q;
    logic              rsp_c_q, rsp_z_q, rsp_o_q, rsp_s_q, rsp_err_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // rst_n gates ready so nothing appears accepted while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign illegal   = is_illegal_op(alu_opsel_q, alu_mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opsel_q  <= '0;
            alu_mode_q   <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            alu_op1_q    <= req_op1[int'(grant_id)*DWIDTH +: DWIDTH];
            alu_op2_q    <= req_op2[int'(grant_id)*DWIDTH +: DWIDTH];
            alu_opsel_q  <= req_opsel[int'(grant_id)*3 +: 3];
            alu_mode_q   <= req_mode[grant_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_o_q      <= 1'b0;
            rsp_s_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (state_q == ISSUE) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= illegal ? '0 : alu_result;
            rsp_c_q      <= !illegal && alu_c;
            rsp_z_q      <= !illegal && alu_z;
            rsp_o_q      <= !illegal && alu_o;
            rsp_s_q      <= !illegal && alu_s;
            rsp_err_q    <= illegal;
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opsel  = alu_opsel_q;
    assign alu_mode   = alu_mode_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_o      = rsp_o_q;
    assign rsp_s      = rsp_s_q;
    assign rsp_err    = rsp_err_q;

endmodule
